muldiv_ctrl: RTL

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_ctrl_pkg.sv | 49 ++++
 rtl/muldiv_step.sv | 45 ++++
 rtl/muldiv_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared pipeline types for the execute stage.
// Holds the ALU function encoding, the 64-bit datapath word type, the state
// type of the iterative multiply/divide unit and a few small helpers.
package pipes;

   typedef logic [63:0] word_t;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9,
      ALU_MULT = 4'd10,
      ALU_DIV  = 4'd11,
      ALU_DIVU = 4'd12,
      ALU_REM  = 4'd13,
      ALU_REMU = 4'd14
   } alufunc_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } muldiv_state_t;

   localparam int MULDIV_ITER = 64;

   // True for the functions handled by the iterative multiply/divide unit.
   function automatic logic is_muldiv(alufunc_t f);
      logic r;
      case (f)
         ALU_MULT, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: r = 1'b1;
         default:                                        r = 1'b0;
      endcase
      return r;
   endfunction

   // Sign-extend a 32-bit W-op result to the full word.
   function automatic word_t sext_word(logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shift-add multiplier / restoring divider (combinational).
// Ports:
//   is_div  : 1 = divide step, 0 = multiply step
//   acc     : MUL product accumulator / DIV partial remainder
//   opx     : MUL shifted multiplicand / DIV dividend-in, quotient-out shifter
//   opy     : MUL multiplier (consumed LSB first) / DIV divisor magnitude
//   *_nxt   : values after this iteration
module muldiv_step
   import pipes::*;
(
   input  logic  is_div,
   input  word_t acc,
   input  word_t opx,
   input  word_t opy,
   output word_t acc_nxt,
   output word_t opx_nxt,
   output word_t opy_nxt
);

   logic [64:0] rem_sh_s;
   logic [64:0] rem_sub_s;
   logic        ge_s;

   // Single iteration: add/shift for multiply, compare/subtract/shift for divide.
   always_comb begin
      // Partial remainder gets the next dividend bit; 65 bits so 2*rem never overflows.
      rem_sh_s  = {acc, opx[63]};
      rem_sub_s = rem_sh_s - {1'b0, opy};
      ge_s      = (rem_sh_s >= {1'b0, opy});
      acc_nxt   = acc;
      opx_nxt   = opx;
      opy_nxt   = opy;
      if (is_div) begin
         // The remainder stays below the divisor, so 64 bits always hold it.
         acc_nxt = ge_s ? rem_sub_s[63:0] : rem_sh_s[63:0];
         opx_nxt = {opx[62:0], ge_s};
         opy_nxt = opy;
      end else begin
         acc_nxt = acc + (opy[0] ? opx : 64'd0);
         opx_nxt = {opx[62:0], 1'b0};
         opy_nxt = {1'b0, opy[63:1]};
      end
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide unit for the execute stage.
// One iteration per cycle: ITER_D cycles for 64-bit ops, ITER_D/2 for W ops.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   start, alufunc   : op request and function (MULT/DIV/DIVU/REM/REMU)
//   is_word          : 32-bit variant, result sign-extended to 64
//   srca, srcb       : operands (multiplicand/dividend, multiplier/divisor)
//   flush, ack       : abort in-flight op / consumer takes result
//   busy, done       : pipeline stall request / result valid
//   result           : final result, stable while done
module muldiv_ctrl
   import pipes::*;
#(
   parameter int ITER_D = MULDIV_ITER
) (
   input  logic     clk,
   input  logic     reset,
   input  logic     start,
   input  alufunc_t alufunc,
   input  logic     is_word,
   input  word_t    srca,
   input  word_t    srcb,
   input  logic     flush,
   input  logic     ack,
   output logic     busy,
   output logic     done,
   output word_t    result
);

   localparam int CNT_W = $clog2(ITER_D) + 1;
   localparam logic [CNT_W-1:0] LAST_D = CNT_W'(ITER_D - 1);
   localparam logic [CNT_W-1:0] LAST_W = CNT_W'(ITER_D / 2 - 1);

   muldiv_state_t    state_r, state_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   alufunc_t         func_r;
   logic             word_r, neg_q_r, neg_r_r, dz_r;
   word_t            acc_r, opx_r, opy_r, result_r;

   logic             accept_s, last_s, signed_op_s, is_div_s;
   logic             sa_s, sb_s, dz_s;
   word_t            a_mag_s, b_mag_s, opx_init_s, opy_init_s;
   word_t            step_acc_s, step_x_s, step_y_s;
   word_t            q_s, r_s, raw_s, fin_s;

   assign is_div_s = (func_r != ALU_MULT);

   muldiv_step u_step (
      .is_div  (is_div_s),
      .acc     (acc_r),
      .opx     (opx_r),
      .opy     (opy_r),
      .acc_nxt (step_acc_s),
      .opx_nxt (step_x_s),
      .opy_nxt (step_y_s)
   );

   // Request qualification and operand preparation (magnitudes, signs, div-by-zero).
   always_comb begin
      accept_s    = start & is_muldiv(alufunc) & ~flush;
      signed_op_s = (alufunc == ALU_DIV) || (alufunc == ALU_REM);
      if (is_word) begin
         sa_s    = signed_op_s & srca[31];
         sb_s    = signed_op_s & srcb[31];
         a_mag_s = {32'd0, sa_s ? (32'd0 - srca[31:0]) : srca[31:0]};
         b_mag_s = {32'd0, sb_s ? (32'd0 - srcb[31:0]) : srcb[31:0]};
         dz_s    = (srcb[31:0] == 32'd0);
      end else begin
         sa_s    = signed_op_s & srca[63];
         sb_s    = signed_op_s & srcb[63];
         a_mag_s = sa_s ? (64'd0 - srca) : srca;
         b_mag_s = sb_s ? (64'd0 - srcb) : srcb;
         dz_s    = (srcb == 64'd0);
      end
      if (alufunc == ALU_MULT) begin
         // Low product bits do not depend on signedness: use raw operands.
         opx_init_s = srca;
         opy_init_s = srcb;
      end else begin
         // W dividends sit in the top half so 32 shifts consume all their bits.
         opx_init_s = is_word ? {a_mag_s[31:0], 32'd0} : a_mag_s;
         opy_init_s = b_mag_s;
      end
   end

   // Final-iteration detection and sign fix-up of the value captured at DONE entry.
   always_comb begin
      last_s = (cnt_r == (word_r ? LAST_W : LAST_D));
      q_s    = step_x_s;
      r_s    = step_acc_s;
      if (dz_r) begin
         q_s = 64'hFFFF_FFFF_FFFF_FFFF;
      end else if (neg_q_r) begin
         q_s = 64'd0 - step_x_s;
      end else begin
         q_s = step_x_s;
      end
      if (neg_r_r) begin
         r_s = 64'd0 - step_acc_s;
      end else begin
         r_s = step_acc_s;
      end
      case (func_r)
         ALU_MULT:           raw_s = step_acc_s;
         ALU_DIV, ALU_DIVU:  raw_s = q_s;
         ALU_REM, ALU_REMU:  raw_s = r_s;
         default:            raw_s = 64'd0;
      endcase
      fin_s = word_r ? sext_word(raw_s[31:0]) : raw_s;
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next state; flush wins over start and ack.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE:    state_nxt_s = accept_s ? RUN : IDLE;
         RUN: begin
            if (flush) begin
               state_nxt_s = IDLE;
            end else if (last_s) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = RUN;
            end
         end
         DONE:    state_nxt_s = (flush || ack) ? IDLE : DONE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // FSM outputs, decoded from the state register only.
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_r)
         IDLE:    begin busy = 1'b0; done = 1'b0; end
         RUN:     begin busy = 1'b1; done = 1'b0; end
         DONE:    begin busy = 1'b1; done = 1'b1; end
         default: begin busy = 1'b0; done = 1'b0; end
      endcase
   end

   // Operand latch, iteration registers, counter and result register.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r    <= '0;
         func_r   <= ALU_ADD;
         word_r   <= 1'b0;
         neg_q_r  <= 1'b0;
         neg_r_r  <= 1'b0;
         dz_r     <= 1'b0;
         acc_r    <= 64'd0;
         opx_r    <= 64'd0;
         opy_r    <= 64'd0;
         result_r <= 64'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  cnt_r   <= '0;
                  func_r  <= alufunc;
                  word_r  <= is_word;
                  neg_q_r <= sa_s ^ sb_s;
                  neg_r_r <= sa_s;
                  dz_r    <= dz_s;
                  acc_r   <= 64'd0;
                  opx_r   <= opx_init_s;
                  opy_r   <= opy_init_s;
               end
            end
            RUN: begin
               if (!flush) begin
                  acc_r <= step_acc_s;
                  opx_r <= step_x_s;
                  opy_r <= step_y_s;
                  cnt_r <= cnt_r + 1'b1;
                  if (last_s) begin
                     result_r <= fin_s;
                  end
               end
            end
            default: begin
               cnt_r <= cnt_r;
            end
         endcase
      end
   end

   assign result = result_r;

endmodule
